// File: rtl/shiftreg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shiftreg_pkg
// Description : Shared types for the universal shift register.
//               op_e     - the eight 3-bit commands
//               state_e  - sequencing FSM states (IDLE / SHIFT)
//               is_shift_op() - true for commands that move bits. ROL/ROR
//               count as shifts only when SHIFTREG_ROTATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package shiftreg_pkg;

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_SAR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        case (op)
            OP_SHL, OP_SHR, OP_SAR: return 1'b1;
`ifdef SHIFTREG_ROTATE_EN
            OP_ROL, OP_ROR:         return 1'b1;
`endif
            default:                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/shiftreg_step.sv
`default_nettype none
// ============================================================================
// Module      : shiftreg_step
// Description : Combinational single-position shift. Given the current
//               register value, the command and the serial fill bit, returns
//               the next register value and the bit shifted out.
//               Rotate branches exist only when SHIFTREG_ROTATE_EN is defined.
// Ports       : i_cur     [WIDTH] current register contents
//               i_op      op_e    shift command
//               i_ser_in  1       serial fill bit (SHL/SHR)
//               o_nxt     [WIDTH] register contents after one step
//               o_ser_out 1       bit leaving the register on this step
// Revision    : 1.0 - initial release
// ============================================================================
module shiftreg_step
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  op_e              i_op,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_ser_out
);

    always_comb begin
        o_nxt     = i_cur;
        o_ser_out = 1'b0;
        case (i_op)
            OP_SHL: begin
                o_nxt     = {i_cur[WIDTH-2:0], i_ser_in};
                o_ser_out = i_cur[WIDTH-1];
            end
            OP_SHR: begin
                o_nxt     = {i_ser_in, i_cur[WIDTH-1:1]};
                o_ser_out = i_cur[0];
            end
            OP_SAR: begin
                o_nxt     = {i_cur[WIDTH-1], i_cur[WIDTH-1:1]};
                o_ser_out = i_cur[0];
            end
`ifdef SHIFTREG_ROTATE_EN
            OP_ROL: begin
                o_nxt     = {i_cur[WIDTH-2:0], i_cur[WIDTH-1]};
                o_ser_out = i_cur[WIDTH-1];
            end
            OP_ROR: begin
                o_nxt     = {i_cur[0], i_cur[WIDTH-1:1]};
                o_ser_out = i_cur[0];
            end
`endif
            default: begin
                o_nxt     = i_cur;
                o_ser_out = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shiftreg_universal.sv
`default_nettype none
// ============================================================================
// Module      : shiftreg_universal
// Description : Parametrised universal shift register with clear, parallel
//               load, SHL/SHR/SAR and optional ROL/ROR. A shift of n
//               positions (n = min(amt, WIDTH)) runs one position per clock;
//               the first step happens on the accept edge.
//               Optional feature macro: SHIFTREG_ROTATE_EN (ROL/ROR enabled;
//               when undefined they behave as NOP).
// Ports       : clk      rising-edge clock
//               rst      asynchronous active-high reset
//               start    command request, accepted only while busy=0
//               op[2:0]  command (see shiftreg_pkg::op_e)
//               amt      shift count, sampled at accept
//               data_in  parallel load value, sampled at accept
//               ser_in   serial fill bit, sampled at every step
//               out      register contents
//               ser_out  bit shifted/rotated out on the latest step
//               busy     multi-step shift in progress
//               done     one-cycle pulse after the completing edge
// Revision    : 1.0 - initial release
// ============================================================================
module shiftreg_universal
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    op_e              r_shift_op;
    logic [WIDTH-1:0] r_out;
    logic             r_ser_out;
    logic             r_done;

    op_e              w_op;
    op_e              w_step_op;
    logic             w_accept;
    logic             w_is_shift;
    logic [CNT_W-1:0] w_amt_eff;
    logic [WIDTH-1:0] w_step_out;
    logic             w_step_ser;
    logic             w_last_step;

    assign w_op        = op_e'(op);
    assign w_accept    = start && (r_state == ST_IDLE);
    assign w_is_shift  = is_shift_op(w_op);
    assign w_amt_eff   = (amt > c_max_cnt) ? c_max_cnt : amt;
    assign w_last_step = (r_remaining == c_one);

    // While shifting, the step unit follows the command captured at accept,
    // so new op values on the bus cannot disturb an ongoing shift.
    assign w_step_op = (r_state == ST_SHIFT) ? r_shift_op : w_op;

    shiftreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_cur     (r_out),
        .i_op      (w_step_op),
        .i_ser_in  (ser_in),
        .o_nxt     (w_step_out),
        .o_ser_out (w_step_ser)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_shift && (w_amt_eff > c_one)) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state == ST_SHIFT);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_ser_out   <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_shift_op  <= OP_NOP;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_SHIFT) begin
                r_out       <= w_step_out;
                r_ser_out   <= w_step_ser;
                r_remaining <= r_remaining - c_one;
                if (w_last_step) begin
                    r_done <= 1'b1;
                end
            end else if (w_accept) begin
                case (w_op)
                    OP_CLR: begin
                        r_out     <= '0;
                        r_ser_out <= 1'b0;
                        r_done    <= 1'b1;
                    end
                    OP_LOAD: begin
                        r_out  <= data_in;
                        r_done <= 1'b1;
                    end
                    default: begin
                        // Disabled rotates, NOP and zero-length shifts all
                        // complete immediately without touching the register.
                        if (w_is_shift && (w_amt_eff != '0)) begin
                            r_out     <= w_step_out;
                            r_ser_out <= w_step_ser;
                            if (w_amt_eff == c_one) begin
                                r_done <= 1'b1;
                            end else begin
                                r_remaining <= w_amt_eff - c_one;
                                r_shift_op  <= w_op;
                            end
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign out     = r_out;
    assign ser_out = r_ser_out;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_universal.sv
`default_nettype none
// ============================================================================
// Module      : tb_shiftreg_universal
// Description : Self-checking bench for shiftreg_universal (WIDTH=8).
//               Table of single-cycle commands, hand-written multi-cycle
//               sequences, and randomized commands against an arithmetic
//               reference model. Honors SHIFTREG_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shiftreg_universal;
    import shiftreg_pkg::*;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MASK = (1 << W) - 1;
`ifdef SHIFTREG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [CW-1:0] amt;
    logic [W-1:0]  data_in;
    logic          ser_in;
    logic [W-1:0]  out;
    logic          ser_out;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mv;
    bit ms;

    shiftreg_universal #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .data_in (data_in),
        .ser_in  (ser_in),
        .out     (out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        op_e          vop;
        logic [CW-1:0] vamt;
        logic [W-1:0] vdin;
        logic         vsi;
        logic [W-1:0] eout;
        logic         eser;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input op_e o, input int a, input int d, input bit si);
        start   = 1'b1;
        op      = o;
        amt     = CW'(a);
        data_in = W'(d);
        ser_in  = si;
    endtask

    // Assert reset between clock edges and check outputs before any edge.
    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        chk({nm, "_out"},  int'(out), 0);
        chk({nm, "_ser"},  int'(ser_out), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        #2 rst = 1'b0;
        tick();
    endtask

    // One shift position, from the arithmetic meaning of each command.
    task automatic model_step(input int o, input bit si);
        int msb;
        int lsb;
        msb = (mv >> (W - 1)) & 1;
        lsb = mv & 1;
        case (o)
            2: begin ms = bit'(msb); mv = ((mv * 2) + int'(si)) & MASK; end
            3: begin ms = bit'(lsb); mv = (mv / 2) + (int'(si) << (W - 1)); end
            4: begin ms = bit'(lsb); mv = (mv / 2) + (msb << (W - 1)); end
            5: begin ms = bit'(msb); mv = ((mv * 2) + msb) & MASK; end
            6: begin ms = bit'(lsb); mv = (mv / 2) + (lsb << (W - 1)); end
            default: ;
        endcase
    endtask

    task automatic run_cmd(input int o, input int a, input int d, input bit idle_after);
        int eff;
        int n;
        int bcnt;
        bit si;
        eff = o;
        if (!ROT && (o == 5 || o == 6)) eff = 7;
        n = (eff >= 2 && eff <= 6) ? ((a > W) ? W : a) : 0;
        si = 1'($urandom_range(0, 1));
        issue(op_e'(3'(o)), a, d, si);
        case (eff)
            0: begin mv = 0; ms = 1'b0; end
            1: mv = d & MASK;
            default: if (n > 0) model_step(eff, si);
        endcase
        tick();
        bcnt = 0;
        for (int k = 1; k < n; k++) begin
            if (busy) bcnt++;
            if (k == 1) chk("rnd_done_lo", int'(done), 0);
            start   = 1'($urandom_range(0, 1));
            op      = 3'($urandom_range(0, 7));
            amt     = CW'($urandom);
            data_in = W'($urandom);
            si      = 1'($urandom_range(0, 1));
            ser_in  = si;
            model_step(eff, si);
            tick();
        end
        start = 1'b0;
        chk("rnd_busy_len", bcnt, (n > 1) ? n - 1 : 0);
        chk("rnd_out",  int'(out), mv);
        chk("rnd_ser",  int'(ser_out), int'(ms));
        chk("rnd_done", int'(done), 1);
        chk("rnd_busy", int'(busy), 0);
        if (idle_after) begin
            tick();
            chk("rnd_done_fall", int'(done), 0);
        end
    endtask

    initial begin
        int bc;
        int dc;
        int edges;
        rst = 1'b1; start = 1'b0; op = 3'b111; amt = '0; data_in = '0; ser_in = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_out",  int'(out), 0);
        chk("rst_ser",  int'(ser_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---------------- table of single-cycle commands ----------------
        tbl[0]  = '{OP_LOAD, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[1]  = '{OP_SHL,  4'd1, 8'h00, 1'b1, 8'h4B, 1'b1};
        tbl[2]  = '{OP_SHR,  4'd1, 8'h00, 1'b0, 8'h25, 1'b1};
        tbl[3]  = '{OP_SAR,  4'd1, 8'h00, 1'b1, 8'h12, 1'b1};
        tbl[4]  = '{OP_NOP,  4'd3, 8'hFF, 1'b0, 8'h12, 1'b1};
        tbl[5]  = '{OP_SHL,  4'd0, 8'hFF, 1'b1, 8'h12, 1'b1};
        tbl[6]  = '{OP_LOAD, 4'd0, 8'h80, 1'b0, 8'h80, 1'b1};
        tbl[7]  = '{OP_SAR,  4'd1, 8'h00, 1'b0, 8'hC0, 1'b0};
        tbl[8]  = '{OP_CLR,  4'd0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{OP_LOAD, 4'd0, 8'h01, 1'b0, 8'h01, 1'b0};
        if (ROT) begin
            tbl[10] = '{OP_ROR, 4'd1, 8'h00, 1'b0, 8'h80, 1'b1};
            tbl[11] = '{OP_ROL, 4'd1, 8'h00, 1'b0, 8'h01, 1'b1};
        end else begin
            tbl[10] = '{OP_ROR, 4'd1, 8'h00, 1'b0, 8'h01, 1'b0};
            tbl[11] = '{OP_ROL, 4'd1, 8'h00, 1'b0, 8'h01, 1'b0};
        end
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].vop, int'(tbl[i].vamt), int'(tbl[i].vdin), tbl[i].vsi);
            tick();
            chk($sformatf("tbl%0d_out", i),  int'(out), int'(tbl[i].eout));
            chk($sformatf("tbl%0d_ser", i),  int'(ser_out), int'(tbl[i].eser));
            chk($sformatf("tbl%0d_done", i), int'(done), 1);
            chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
        end
        start = 1'b0;
        tick();
        chk("idle_done_low", int'(done), 0);

        // ---------------- async reset mid-clock ----------------
        issue(OP_LOAD, 0, 8'h5A, 1'b0);
        tick();
        start = 1'b0;
        async_reset("arst");

        // ---------------- LOAD A5, SHL 3 with ser_in=1 ----------------
        issue(OP_LOAD, 0, 8'hA5, 1'b0); tick();
        issue(OP_SHL, 3, 0, 1'b1);      tick();
        start = 1'b0;
        chk("shl3_e1_out", int'(out), 8'h4B);
        chk("shl3_e1_busy", int'(busy), 1);
        tick();
        chk("shl3_e2_out", int'(out), 8'h97);
        chk("shl3_e2_busy", int'(busy), 1);
        chk("shl3_e2_done", int'(done), 0);
        tick();
        chk("shl3_e3_out", int'(out), 8'h2F);
        chk("shl3_e3_ser", int'(ser_out), 1);
        chk("shl3_e3_busy", int'(busy), 0);
        chk("shl3_e3_done", int'(done), 1);
        tick();
        chk("shl3_done_fall", int'(done), 0);

        // ---------------- LOAD 81, SAR 15 (clamped to 8) ----------------
        issue(OP_LOAD, 0, 8'h81, 1'b0); tick();
        issue(OP_SAR, 15, 0, 1'b0);     tick();
        start = 1'b0;
        bc = 0; dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bc++;
            if (done) dc++;
            tick();
        end
        chk("sar15_out", int'(out), 8'hFF);
        chk("sar15_busy_cycles", bc, 7);
        chk("sar15_done_pulses", dc, 1);

        // ---------------- LOAD 3C, ROR 4 ----------------
        issue(OP_LOAD, 0, 8'h3C, 1'b0); tick();
        issue(OP_ROR, 4, 0, 1'b0);      tick();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
        chk("ror4_out", int'(out), ROT ? 8'hC3 : 8'h3C);
        chk("ror4_edges", edges, ROT ? 4 : 1);

        // ---------------- SHR 5 on F0, LOAD ignored mid-shift ----------------
        issue(OP_LOAD, 0, 8'hF0, 1'b0); tick();
        issue(OP_SHR, 5, 0, 1'b0);      tick();
        issue(OP_LOAD, 0, 8'hFF, 1'b0); tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("shr5_out", int'(out), 8'h07);
        chk("shr5_done", int'(done), 1);

        // same, reset after 2 steps
        issue(OP_LOAD, 0, 8'hF0, 1'b0); tick();
        issue(OP_SHR, 5, 0, 1'b0);      tick();
        start = 1'b0;
        tick();
        chk("shr5r_out_mid", int'(out), 8'h3C);
        async_reset("shr5r");
        issue(OP_LOAD, 0, 8'h5A, 1'b0); tick();
        start = 1'b0;
        chk("post_rst_load_out", int'(out), 8'h5A);
        chk("post_rst_load_done", int'(done), 1);

        // ---------------- SHL amt=0 on 0x12 ----------------
        issue(OP_LOAD, 0, 8'h12, 1'b0); tick();
        issue(OP_SHL, 0, 0, 1'b1);      tick();
        start = 1'b0;
        chk("shl0_out", int'(out), 8'h12);
        chk("shl0_busy", int'(busy), 0);
        chk("shl0_done", int'(done), 1);
        tick();
        chk("shl0_done_fall", int'(done), 0);
        chk("shl0_out_hold", int'(out), 8'h12);

        // ---------------- randomized commands vs model ----------------
        mv = int'(out);
        ms = ser_out;
        for (int i = 0; i < 200; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
